// File: rtl/datamem_arbiter.sv
// Two-port arbiter/sequencer in front of the single-ported datamem block.
// Define DATAMEM_ARB_RR_EN for round-robin arbitration instead of fixed priority with starvation guard.
module datamem_arbiter #(
    parameter int AW       = 10,
    parameter int DW       = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic          mem_readMem,
    output logic          mem_writeMem,
    output logic [AW-1:0] mem_R_addr,
    output logic [AW-1:0] mem_W_addr,
    output logic [DW-1:0] mem_W_data,
    input  logic [DW-1:0] mem_R_data
);

    logic          pick1;
    logic          iss_valid_q, iss_valid_d;
    logic          iss_we_q, iss_we_d;
    logic          iss_port_q, iss_port_d;
    logic [AW-1:0] iss_addr_q, iss_addr_d;
    logic [DW-1:0] iss_wdata_q, iss_wdata_d;
    logic          rvalid0_q, rvalid0_d;
    logic          rvalid1_q, rvalid1_d;
    logic [DW-1:0] rdata0_q, rdata0_d;
    logic [DW-1:0] rdata1_q, rdata1_d;

`ifdef DATAMEM_ARB_RR_EN
    // last1_q remembers which port won most recently; ties go to the other one.
    logic last1_q, last1_d;

    always_comb begin
        pick1 = 1'b0;
        if (req1 && !req0) begin
            pick1 = 1'b1;
        end else if (req1 && req0) begin
            pick1 = !last1_q;
        end
        last1_d = last1_q;
        if (gnt1) begin
            last1_d = 1'b1;
        end else if (gnt0) begin
            last1_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            last1_q <= 1'b1;
        end else begin
            last1_q <= last1_d;
        end
    end
`else
    localparam int WW = $clog2(MAX_WAIT + 1);
    logic [WW-1:0] wait1_q, wait1_d;
    logic          force1;

    always_comb begin
        force1  = (wait1_q == WW'(MAX_WAIT));
        pick1   = req1 && (!req0 || force1);
        wait1_d = wait1_q;
        if (!req1 || gnt1) begin
            wait1_d = '0;
        end else if (!force1) begin
            wait1_d = wait1_q + WW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wait1_q <= '0;
        end else begin
            wait1_q <= wait1_d;
        end
    end
`endif

    assign gnt0 = rst && req0 && !pick1;
    assign gnt1 = rst && pick1;

    // Address and write data hold their last values when nothing is issued.
    always_comb begin
        iss_valid_d = gnt0 || gnt1;
        iss_we_d    = iss_we_q;
        iss_port_d  = iss_port_q;
        iss_addr_d  = iss_addr_q;
        iss_wdata_d = iss_wdata_q;
        if (gnt1) begin
            iss_we_d    = we1;
            iss_port_d  = 1'b1;
            iss_addr_d  = addr1;
            iss_wdata_d = wdata1;
        end else if (gnt0) begin
            iss_we_d    = we0;
            iss_port_d  = 1'b0;
            iss_addr_d  = addr0;
            iss_wdata_d = wdata0;
        end
        rvalid0_d = iss_valid_q && !iss_we_q && !iss_port_q;
        rvalid1_d = iss_valid_q && !iss_we_q && iss_port_q;
        rdata0_d  = rvalid0_d ? mem_R_data : rdata0_q;
        rdata1_d  = rvalid1_d ? mem_R_data : rdata1_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            iss_valid_q <= 1'b0;
            iss_we_q    <= 1'b0;
            iss_port_q  <= 1'b0;
            iss_addr_q  <= '0;
            iss_wdata_q <= '0;
            rvalid0_q   <= 1'b0;
            rvalid1_q   <= 1'b0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
        end else begin
            iss_valid_q <= iss_valid_d;
            iss_we_q    <= iss_we_d;
            iss_port_q  <= iss_port_d;
            iss_addr_q  <= iss_addr_d;
            iss_wdata_q <= iss_wdata_d;
            rvalid0_q   <= rvalid0_d;
            rvalid1_q   <= rvalid1_d;
            rdata0_q    <= rdata0_d;
            rdata1_q    <= rdata1_d;
        end
    end

    assign mem_readMem  = iss_valid_q && !iss_we_q;
    assign mem_writeMem = iss_valid_q && iss_we_q;
    assign mem_R_addr   = iss_addr_q;
    assign mem_W_addr   = iss_addr_q;
    assign mem_W_data   = iss_wdata_q;
    assign rvalid0      = rvalid0_q;
    assign rvalid1      = rvalid1_q;
    assign rdata0       = rdata0_q;
    assign rdata1       = rdata1_q;

endmodule

// File: tb/tb_datamem_arbiter.sv
// Directed bench for datamem_arbiter with an asynchronous-read memory model.
// Expectations follow the build selected by DATAMEM_ARB_RR_EN.
module tb_datamem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1, we0, we1;
    logic [9:0]  addr0, addr1;
    logic [31:0] wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1;
    logic [31:0] rdata0, rdata1;
    logic        mem_readMem, mem_writeMem;
    logic [9:0]  mem_R_addr, mem_W_addr;
    logic [31:0] mem_W_data, mem_R_data;
    logic [31:0] mem_model [0:1023];

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        r0;
        logic        w0;
        logic [9:0]  a0;
        logic [31:0] d0;
        logic        r1;
        logic        w1;
        logic [9:0]  a1;
        logic [31:0] d1;
        logic [1:0]  eg;
        logic [1:0]  eg_rr;
        logic        erd;
        logic        ewr;
    } vec_t;

    vec_t vecs [12];

    datamem_arbiter #(.AW(10), .DW(32), .MAX_WAIT(4)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1),
        .mem_readMem(mem_readMem), .mem_writeMem(mem_writeMem),
        .mem_R_addr(mem_R_addr), .mem_W_addr(mem_W_addr),
        .mem_W_data(mem_W_data), .mem_R_data(mem_R_data)
    );

    always #5 clk = ~clk;

    // Memory model: combinational read, write lands on the clock edge.
    initial begin
        for (int i = 0; i < 1024; i++) mem_model[i] = 32'h1000 + i;
        forever begin
            @(posedge clk);
            if (mem_writeMem) mem_model[mem_W_addr] = mem_W_data;
        end
    end
    assign mem_R_data = mem_model[mem_R_addr];

    task automatic applyStimulus(input logic r0, input logic w0, input logic [9:0] a0,
                                 input logic [31:0] d0, input logic r1, input logic w1,
                                 input logic [9:0] a1, input logic [31:0] d1);
        @(negedge clk);
        req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
        req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, 10'd0, 32'd0, 1'b0, 1'b0, 10'd0, 32'd0);
    endtask

    initial begin
        logic [1:0] eg;
        // row: r0 w0 a0 d0 | r1 w1 a1 d1 | gnt{1,0} fixed | gnt{1,0} rr | rd wr
        vecs[0]  = '{1'b0, 1'b0, 10'd0, 32'd0, 1'b0, 1'b0, 10'd0, 32'd0,  2'b00, 2'b00, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 10'd1, 32'd0, 1'b0, 1'b0, 10'd0, 32'd0,  2'b01, 2'b01, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 10'd0, 32'd0, 1'b1, 1'b1, 10'd2, 32'd5,  2'b10, 2'b10, 1'b1, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 10'd4, 32'd0, 1'b1, 1'b0, 10'd5, 32'd0,  2'b01, 2'b01, 1'b0, 1'b1};
        vecs[4]  = '{1'b1, 1'b0, 10'd4, 32'd0, 1'b1, 1'b0, 10'd5, 32'd0,  2'b01, 2'b10, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 10'd4, 32'd0, 1'b0, 1'b0, 10'd5, 32'd0,  2'b01, 2'b01, 1'b1, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 10'd4, 32'd0, 1'b1, 1'b0, 10'd5, 32'd0,  2'b01, 2'b10, 1'b1, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 10'd4, 32'd0, 1'b1, 1'b0, 10'd5, 32'd0,  2'b01, 2'b01, 1'b1, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 10'd4, 32'd0, 1'b1, 1'b0, 10'd5, 32'd0,  2'b01, 2'b10, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 10'd4, 32'd0, 1'b1, 1'b0, 10'd5, 32'd0,  2'b01, 2'b01, 1'b1, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 10'd4, 32'd0, 1'b1, 1'b0, 10'd5, 32'd0,  2'b10, 2'b10, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 10'd0, 32'd0, 1'b0, 1'b0, 10'd0, 32'd0,  2'b00, 2'b00, 1'b1, 1'b0};

        req0 = 0; req1 = 0; we0 = 0; we1 = 0; addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
        rst = 1'b0;

        // Reset state, with a request present to show grants are masked.
        applyStimulus(1'b1, 1'b0, 10'd7, 32'd0, 1'b1, 1'b0, 10'd8, 32'd0);
        applyStimulus(1'b1, 1'b0, 10'd7, 32'd0, 1'b1, 1'b0, 10'd8, 32'd0);
        checkOutput("rst_gnt0", {31'd0, gnt0}, 32'd0);
        checkOutput("rst_gnt1", {31'd0, gnt1}, 32'd0);
        checkOutput("rst_rd", {31'd0, mem_readMem}, 32'd0);
        checkOutput("rst_wr", {31'd0, mem_writeMem}, 32'd0);
        checkOutput("rst_rvalid0", {31'd0, rvalid0}, 32'd0);
        checkOutput("rst_addr", {22'd0, mem_R_addr}, 32'd0);
        idle();
        rst = 1'b1;

        // Table-driven arbitration / control vectors.
        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].r0, vecs[i].w0, vecs[i].a0, vecs[i].d0,
                          vecs[i].r1, vecs[i].w1, vecs[i].a1, vecs[i].d1);
`ifdef DATAMEM_ARB_RR_EN
            eg = vecs[i].eg_rr;
`else
            eg = vecs[i].eg;
`endif
            checkOutput($sformatf("vec%0d_gnt", i), {30'd0, gnt1, gnt0}, {30'd0, eg});
            checkOutput($sformatf("vec%0d_rd", i), {31'd0, mem_readMem}, {31'd0, vecs[i].erd});
            checkOutput($sformatf("vec%0d_wr", i), {31'd0, mem_writeMem}, {31'd0, vecs[i].ewr});
        end

        // Write then read on port 0, same address.
        applyStimulus(1'b1, 1'b1, 10'd3, 32'hDEADBEEF, 1'b0, 1'b0, 10'd0, 32'd0);
        checkOutput("wr_gnt0", {31'd0, gnt0}, 32'd1);
        applyStimulus(1'b1, 1'b0, 10'd3, 32'd0, 1'b0, 1'b0, 10'd0, 32'd0);
        checkOutput("wr_pulse", {31'd0, mem_writeMem}, 32'd1);
        checkOutput("wr_addr", {22'd0, mem_W_addr}, 32'd3);
        checkOutput("wr_data", mem_W_data, 32'hDEADBEEF);
        checkOutput("rd_gnt0", {31'd0, gnt0}, 32'd1);
        idle();
        checkOutput("rd_ctl", {31'd0, mem_readMem}, 32'd1);
        checkOutput("rd_noearly", {31'd0, rvalid0}, 32'd0);
        idle();
        checkOutput("raw_rvalid0", {31'd0, rvalid0}, 32'd1);
        checkOutput("raw_rdata0", rdata0, 32'hDEADBEEF);
        idle();
        checkOutput("raw_pulse", {31'd0, rvalid0}, 32'd0);

        // Back-to-back alternation after port 1 preloads.
        applyStimulus(1'b0, 1'b0, 10'd0, 32'd0, 1'b1, 1'b1, 10'd10, 32'h11);
        applyStimulus(1'b0, 1'b0, 10'd0, 32'd0, 1'b1, 1'b1, 10'd11, 32'h22);
        applyStimulus(1'b1, 1'b0, 10'd10, 32'd0, 1'b0, 1'b0, 10'd0, 32'd0);
        checkOutput("alt_gnt0", {31'd0, gnt0}, 32'd1);
        applyStimulus(1'b0, 1'b0, 10'd0, 32'd0, 1'b1, 1'b0, 10'd11, 32'd0);
        checkOutput("alt_gnt1", {31'd0, gnt1}, 32'd1);
        idle();
        checkOutput("alt_rvalid0", {31'd0, rvalid0}, 32'd1);
        checkOutput("alt_rdata0", rdata0, 32'h11);
        checkOutput("alt_rvalid1_lo", {31'd0, rvalid1}, 32'd0);
        checkOutput("alt_rdata1_hold", rdata1, 32'h1005);
        idle();
        checkOutput("alt_rvalid1", {31'd0, rvalid1}, 32'd1);
        checkOutput("alt_rdata1", rdata1, 32'h22);
        checkOutput("alt_rvalid0_lo", {31'd0, rvalid0}, 32'd0);
        checkOutput("alt_rdata0_hold", rdata0, 32'h11);

        // Reset arriving the cycle after a read grant drops it.
        applyStimulus(1'b1, 1'b0, 10'd5, 32'd0, 1'b0, 1'b0, 10'd0, 32'd0);
        checkOutput("mid_gnt0", {31'd0, gnt0}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("mid_gnt_masked", {31'd0, gnt0}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        req0 = 1'b0;
        #1;
        checkOutput("mid_rvalid0", {31'd0, rvalid0}, 32'd0);
        checkOutput("mid_rd", {31'd0, mem_readMem}, 32'd0);
        checkOutput("mid_wr", {31'd0, mem_writeMem}, 32'd0);
        checkOutput("mid_addr", {22'd0, mem_R_addr}, 32'd0);
        checkOutput("mid_wdata", mem_W_data, 32'd0);
        checkOutput("mid_rdata0", rdata0, 32'd0);
        checkOutput("mid_rdata1", rdata1, 32'd0);
        idle();
        checkOutput("mid_rvalid0_after", {31'd0, rvalid0}, 32'd0);

        // Both ports held continuously from a clean post-reset state.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 1'b0, 10'd20, 32'd0, 1'b1, 1'b0, 10'd21, 32'd0);
`ifdef DATAMEM_ARB_RR_EN
            eg = (i % 2 == 1) ? 2'b10 : 2'b01;
`else
            eg = (i % 5 == 4) ? 2'b10 : 2'b01;
`endif
            checkOutput($sformatf("starve%0d", i), {30'd0, gnt1, gnt0}, {30'd0, eg});
        end

        // Idle: drain, then watch 10 cycles of silence.
        for (int i = 0; i < 3; i++) idle();
        for (int i = 0; i < 10; i++) begin
            idle();
            checkOutput($sformatf("idle%0d_rd", i), {31'd0, mem_readMem}, 32'd0);
            checkOutput($sformatf("idle%0d_wr", i), {31'd0, mem_writeMem}, 32'd0);
            checkOutput($sformatf("idle%0d_rv", i), {30'd0, rvalid1, rvalid0}, 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
